// File: rtl/multicycle_main_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_main_fsm
//
// Main controller for the ARMv4 multicycle processor. Steps the shared
// datapath through fetch, decode, execute, memory and writeback. It drives
// the datapath mux selects and the raw regW/memW/branch strobes, which
// ConditionLogic later qualifies against cond/flags. A memory-ready
// handshake holds FETCH, MEMREAD and MEMWRITE until slow memory finishes.
//
// Ports:
//   clk_i        single clock, rising edge
//   rst_ni       synchronous reset, active low
//   op_i         instruction bits [27:26]
//   funct_i      instruction bits [25:20]; [5] = I, [0] = S/L
//   memReady_i   memory completed the current access this cycle
//   irWrite_o    load the instruction register
//   nextPC_o     PC write enable for sequential fetch
//   adrSrc_o     memory address select (0 = PC, 1 = ALU result register)
//   aluSrcA_o    ALU A select (0 = Rn, 1 = PC)
//   aluSrcB_o    ALU B select (00 = Rm, 01 = ext imm, 10 = constant 4)
//   resultSrc_o  result select (00 = ALU out reg, 01 = data reg, 10 = ALU)
//   aluOp_o      1 = ALU decoder decodes funct, 0 = force ADD
//   regW_o       raw register-write strobe
//   memW_o       raw memory-write strobe
//   branch_o     raw branch strobe
//   undefOp_o    one-cycle pulse when DECODE sees op = 11
//   state_o      current state code (debug)
// ---------------------------------------------------------------------------
module multicycle_main_fsm (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       memReady_i,
  output logic       irWrite_o,
  output logic       nextPC_o,
  output logic       adrSrc_o,
  output logic       aluSrcA_o,
  output logic [1:0] aluSrcB_o,
  output logic [1:0] resultSrc_o,
  output logic       aluOp_o,
  output logic       regW_o,
  output logic       memW_o,
  output logic       branch_o,
  output logic       undefOp_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t state_q, state_d;

  // The output decoder looks at FETCH while reset is held, so the selects
  // show fetch values and a reset mid-instruction drops memW at once.
  state_t decState;

  // Only the I and L bits steer the sequence; the rest of funct belongs to
  // the ALU decoder.
  logic unusedFunct;
  assign unusedFunct = ^funct_i[4:1];

  assign state_o = state_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    unique case (state_q)
      FETCH:    state_d = memReady_i ? DECODE : FETCH;
      DECODE: begin
        unique case (op_i)
          2'b00:   state_d = funct_i[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = funct_i[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = memReady_i ? MEMWB : MEMREAD;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = memReady_i ? FETCH : MEMWRITE;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    decState    = rst_ni ? state_q : FETCH;
    irWrite_o   = 1'b0;
    nextPC_o    = 1'b0;
    adrSrc_o    = 1'b0;
    aluSrcA_o   = 1'b0;
    aluSrcB_o   = 2'b00;
    resultSrc_o = 2'b00;
    aluOp_o     = 1'b0;
    regW_o      = 1'b0;
    memW_o      = 1'b0;
    branch_o    = 1'b0;
    undefOp_o   = 1'b0;
    unique case (decState)
      FETCH: begin
        aluSrcA_o   = 1'b1;
        aluSrcB_o   = 2'b10;
        resultSrc_o = 2'b10;
        irWrite_o   = memReady_i;
        nextPC_o    = memReady_i;
      end
      DECODE: begin
        aluSrcA_o   = 1'b1;
        aluSrcB_o   = 2'b10;
        resultSrc_o = 2'b10;
        undefOp_o   = (op_i == 2'b11);
      end
      MEMADR:   aluSrcB_o = 2'b01;
      MEMREAD:  adrSrc_o  = 1'b1;
      MEMWB: begin
        resultSrc_o = 2'b01;
        regW_o      = 1'b1;
      end
      MEMWRITE: begin
        adrSrc_o = 1'b1;
        memW_o   = 1'b1;
      end
      EXECUTER: aluOp_o = 1'b1;
      EXECUTEI: begin
        aluSrcB_o = 2'b01;
        aluOp_o   = 1'b1;
      end
      ALUWB:    regW_o = 1'b1;
      BRANCH: begin
        aluSrcB_o   = 2'b01;
        resultSrc_o = 2'b10;
        branch_o    = 1'b1;
      end
      default: ;
    endcase
    // Strobes are killed outright in reset, independent of the decode.
    if (!rst_ni) begin
      irWrite_o = 1'b0;
      nextPC_o  = 1'b0;
      regW_o    = 1'b0;
      memW_o    = 1'b0;
      branch_o  = 1'b0;
      undefOp_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_main_fsm
//
// Directed bench for the multicycle main controller. Walks reset, LDR,
// stalled STR, both data-processing forms, branch, undefined opcode, a
// fetch stall and a reset in the middle of a store. Each cycle checks the
// state code, the strobe bundle and the select bundle against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_multicycle_main_fsm;

  logic       clk;
  logic       rst;
  logic [1:0] op;
  logic [5:0] funct;
  logic       memReady;
  logic       irWrite, nextPC, adrSrc, aluSrcA, aluOp;
  logic [1:0] aluSrcB, resultSrc;
  logic       regW, memW, branch, undefOp;
  logic [3:0] state;

  int nAsserts = 0;
  int nFail    = 0;

  // Strobe bundle {2'b0, irWrite, nextPC, regW, memW, branch, undefOp}
  localparam logic [7:0] S_NONE  = 8'h00;
  localparam logic [7:0] S_FETCH = 8'h30;
  localparam logic [7:0] S_REGW  = 8'h08;
  localparam logic [7:0] S_MEMW  = 8'h04;
  localparam logic [7:0] S_BR    = 8'h02;
  localparam logic [7:0] S_UNDEF = 8'h01;

  // Select bundle {1'b0, adrSrc, aluSrcA, aluSrcB, resultSrc, aluOp}
  localparam logic [7:0] X_FETCH = 8'h34;
  localparam logic [7:0] X_MADR  = 8'h08;
  localparam logic [7:0] X_MEMA  = 8'h40;
  localparam logic [7:0] X_MEMWB = 8'h02;
  localparam logic [7:0] X_EXR   = 8'h01;
  localparam logic [7:0] X_EXI   = 8'h09;
  localparam logic [7:0] X_ALUWB = 8'h00;
  localparam logic [7:0] X_BR    = 8'h0C;

  logic [7:0] stateW, strobeW, selW;
  assign stateW  = {4'b0, state};
  assign strobeW = {2'b0, irWrite, nextPC, regW, memW, branch, undefOp};
  assign selW    = {1'b0, adrSrc, aluSrcA, aluSrcB, resultSrc, aluOp};

  multicycle_main_fsm dut (
    .clk_i       (clk),
    .rst_ni      (rst),
    .op_i        (op),
    .funct_i     (funct),
    .memReady_i  (memReady),
    .irWrite_o   (irWrite),
    .nextPC_o    (nextPC),
    .adrSrc_o    (adrSrc),
    .aluSrcA_o   (aluSrcA),
    .aluSrcB_o   (aluSrcB),
    .resultSrc_o (resultSrc),
    .aluOp_o     (aluOp),
    .regW_o      (regW),
    .memW_o      (memW),
    .branch_o    (branch),
    .undefOp_o   (undefOp),
    .state_o     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts, asserts and reports on failure.
  task automatic checkOutput(input string tag, input logic [7:0] obs,
                             input logic [7:0] exp);
    nAsserts++;
    assert (obs === exp)
      else begin
        nFail++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Settle the freshly driven inputs, check one cycle, then clock it.
  task automatic applyStimulus(input string tag, input logic [7:0] expState,
                               input logic [7:0] expStb,
                               input logic [7:0] expSel);
    #1;
    checkOutput({tag, ".state"}, stateW, expState);
    checkOutput({tag, ".strobes"}, strobeW, expStb);
    checkOutput({tag, ".selects"}, selW, expSel);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b0;
    op       = 2'b00;
    funct    = 6'b000000;
    memReady = 1'b1;
    @(posedge clk);
    #1;

    // Reset held: FETCH code, strobes dead, fetch selects visible
    applyStimulus("rst0", 8'd0, S_NONE, X_FETCH);
    applyStimulus("rst1", 8'd0, S_NONE, X_FETCH);
    applyStimulus("rst2", 8'd0, S_NONE, X_FETCH);

    // LDR, starting with the first live fetch
    op    = 2'b01;
    funct = 6'b011001;
    rst   = 1'b1;
    applyStimulus("ldr.fetch",   8'd0, S_FETCH, X_FETCH);
    applyStimulus("ldr.decode",  8'd1, S_NONE,  X_FETCH);
    applyStimulus("ldr.memadr",  8'd2, S_NONE,  X_MADR);
    applyStimulus("ldr.memread", 8'd3, S_NONE,  X_MEMA);
    applyStimulus("ldr.memwb",   8'd4, S_REGW,  X_MEMWB);

    // STR with two stalled MEMWRITE cycles
    funct = 6'b011000;
    applyStimulus("str.fetch",  8'd0, S_FETCH, X_FETCH);
    applyStimulus("str.decode", 8'd1, S_NONE,  X_FETCH);
    applyStimulus("str.memadr", 8'd2, S_NONE,  X_MADR);
    memReady = 1'b0;
    applyStimulus("str.wr0", 8'd5, S_MEMW, X_MEMA);
    applyStimulus("str.wr1", 8'd5, S_MEMW, X_MEMA);
    memReady = 1'b1;
    applyStimulus("str.wr2", 8'd5, S_MEMW, X_MEMA);

    // Data-processing, register form
    op    = 2'b00;
    funct = 6'b001000;
    applyStimulus("dpr.fetch",  8'd0, S_FETCH, X_FETCH);
    applyStimulus("dpr.decode", 8'd1, S_NONE,  X_FETCH);
    applyStimulus("dpr.exec",   8'd6, S_NONE,  X_EXR);
    applyStimulus("dpr.aluwb",  8'd8, S_REGW,  X_ALUWB);

    // Data-processing, immediate form
    funct = 6'b101000;
    applyStimulus("dpi.fetch",  8'd0, S_FETCH, X_FETCH);
    applyStimulus("dpi.decode", 8'd1, S_NONE,  X_FETCH);
    applyStimulus("dpi.exec",   8'd7, S_NONE,  X_EXI);
    applyStimulus("dpi.aluwb",  8'd8, S_REGW,  X_ALUWB);

    // Branch
    op    = 2'b10;
    funct = 6'b000000;
    applyStimulus("b.fetch",  8'd0, S_FETCH, X_FETCH);
    applyStimulus("b.decode", 8'd1, S_NONE,  X_FETCH);
    applyStimulus("b.branch", 8'd9, S_BR,    X_BR);

    // Undefined opcode
    op = 2'b11;
    applyStimulus("und.fetch",  8'd0, S_FETCH, X_FETCH);
    applyStimulus("und.decode", 8'd1, S_UNDEF, X_FETCH);

    // Fetch stall for four cycles
    op       = 2'b01;
    funct    = 6'b011000;
    memReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus("fstall", 8'd0, S_NONE, X_FETCH);
    end

    // STR with reset asserted during MEMWRITE
    memReady = 1'b1;
    applyStimulus("rstr.fetch",  8'd0, S_FETCH, X_FETCH);
    applyStimulus("rstr.decode", 8'd1, S_NONE,  X_FETCH);
    applyStimulus("rstr.memadr", 8'd2, S_NONE,  X_MADR);
    rst = 1'b0;
    applyStimulus("rstr.wrrst", 8'd5, S_NONE, X_FETCH);
    applyStimulus("rstr.after", 8'd0, S_NONE, X_FETCH);
    rst = 1'b1;
    applyStimulus("rstr.refetch", 8'd0, S_FETCH, X_FETCH);
    applyStimulus("rstr.redecode", 8'd1, S_NONE, X_FETCH);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAsserts, nFail);
    $finish;
  end

endmodule
